if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: icache_addr  output  32  fetch address to icache; word-aligned.
REQ-005 Port: icache_req  output  1  fetch request; held with icache_addr stable until icache_valid.
REQ-006 Port: icache_data  input  32  instruction word returned by icache.
REQ-007 Port: icache_valid  input  1  icache_data valid for the current request; one-cycle pulse per request.
REQ-008 Port: redirect  input  1  flush and restart fetch at redirect_pc (branch/jump/trap).
REQ-009 Port: redirect_pc  input  32  restart address; bits [1:0] ignored and treated as 0.
REQ-010 Port: inst_valid  output  1  inst/inst_pc hold a fetched instruction.
REQ-011 Port: inst_ready  input  1  decode accepts inst this cycle.
REQ-012 Port: inst  output  32  instruction word at FIFO head.
REQ-013 Port: inst_pc  output  32  address of inst.

Function
REQ-014 Block SHALL hold a 2-entry FIFO of {pc, inst}; inst/inst_pc SHALL show the head entry.
REQ-015 inst_valid SHALL equal (count != 0) AND NOT redirect; a pop occurs when inst_valid and inst_ready are both 1.
REQ-016 At most one icache request SHALL be outstanding.
REQ-017 icache_req SHALL be 1 exactly in states WAIT and DRAIN.
REQ-018 FSM states: IDLE (no request), WAIT (request outstanding, response kept), DRAIN (request outstanding, response discarded).
REQ-019 IDLE, no redirect, count < 2: next state WAIT, icache_addr <= pc.
REQ-020 IDLE, redirect: flush FIFO, next state WAIT, icache_addr <= redirect_pc.
REQ-021 WAIT, icache_valid, no redirect: push {icache_addr, icache_data}.
  - Next address = icache_addr + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - Stays WAIT at the next address if count after push/pop < 2, else goes IDLE with pc = next address.
REQ-022 WAIT, redirect with icache_valid the same cycle: discard the data, flush FIFO, next state WAIT at redirect_pc.
REQ-023 WAIT, redirect without icache_valid: flush FIFO, latch redirect_pc, next state DRAIN; icache_addr/req unchanged.
REQ-024 DRAIN, icache_valid: discard data, next state WAIT, icache_addr <= latched pc (or redirect_pc if redirect is also high this cycle).
REQ-025 DRAIN, redirect without icache_valid: overwrite the latched pc (latest redirect wins).
REQ-026 Push and pop in the same cycle SHALL leave count unchanged; FIFO SHALL never overflow or underflow.
REQ-027 Redirect SHALL flush all FIFO entries in its cycle; push and pop in that cycle SHALL be suppressed.
REQ-028 Latency: icache_valid sampled at edge N -> inst_valid = 1 after edge N (earliest).
  - With single-cycle icache hits and inst_ready held 1, sustained throughput is one instruction per 2 cycles.
REQ-029 icache_valid arriving in IDLE SHALL be ignored.

Reset
REQ-030 While rst = 1, asynchronously:
  - state = IDLE, pc = RESET_PC, count = 0, latched pc = 0.
  - icache_req = 0, icache_addr = RESET_PC.
  - inst_valid = 0; inst and inst_pc storage = 0.
REQ-031 First icache_req = 1 at the first rising edge after rst deasserts.
REQ-032 rst asserted mid-request SHALL abandon the outstanding request; any late icache_valid is ignored (IDLE rule).

Verification
REQ-033 Bench SHALL use an icache model answering valid one cycle after req, data = addr XOR 32'hA5A5_A5A5, and SHALL cover:
  - Reset, inst_ready = 1 -> inst_pc sequence 0, 4, 8, 12; inst = inst_pc XOR A5A5_A5A5; no gaps or duplicates.
  - inst_ready = 0 for 10 cycles -> count = 2 (pc 0, 4), icache_req = 0; release -> 0, 4, 8 in order.
  - Redirect to 32'h0000_0103 while in WAIT without valid -> DRAIN, stale data dropped; next inst_pc = 32'h100.
  - Redirect coincident with icache_valid -> data dropped, next icache_addr = redirect target, FIFO empty.
  - Redirect to 32'hFFFF_FFF8 -> inst_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - rst pulse while WAIT with count = 1 -> all outputs at reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage -- instruction fetch stage
//
// Fetches instruction words from the icache and buffers them in a 2-entry
// FIFO of {pc, inst} for the decode stage. At most one icache request is
// outstanding at a time. A redirect (branch/jump/trap) flushes the FIFO and
// restarts fetch at the new address. If a request is already in flight when
// the redirect arrives, its response is awaited and discarded (DRAIN) before
// the new address is requested.
//
// Ports
//   clk           in   single clock, rising edge
//   rst           in   asynchronous, active-high reset
//   icache_addr   out  [31:0] word-aligned fetch address, stable while req=1
//   icache_req    out  fetch request, held until icache_valid
//   icache_data   in   [31:0] instruction word for the current request
//   icache_valid  in   one-cycle pulse: icache_data is valid
//   redirect      in   flush and restart fetch at redirect_pc
//   redirect_pc   in   [31:0] restart address (bits [1:0] forced to 0)
//   inst_valid    out  inst/inst_pc hold a fetched instruction
//   inst_ready    in   decode accepts inst this cycle
//   inst          out  [31:0] instruction word at FIFO head
//   inst_pc       out  [31:0] address of inst
// ----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] icache_addr,
  output logic        icache_req,
  input  logic [31:0] icache_data,
  input  logic        icache_valid,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  // IDLE : no request outstanding
  // WAIT : request outstanding, its response will be pushed
  // DRAIN: request outstanding, its response will be dropped (stale)
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  state_e      state_q;
  logic [31:0] pc_q;          // next fetch address while IDLE
  logic [31:0] addr_q;        // address of the outstanding request
  logic [31:0] latched_pc_q;  // redirect target held while draining
  logic        req_q;
  logic [1:0]  count_q;
  logic [1:0]  count_d;
  entry_t      fifo_q [2];    // slot 0 is always the head

  logic [31:0] target_pc;
  logic [31:0] next_addr;
  logic        push;
  logic        pop;
  logic        wr_idx;
  entry_t      new_entry;

  assign target_pc = redirect_pc & 32'hFFFF_FFFC;
  assign next_addr = addr_q + 32'd4;  // wraps modulo 2^32

  // A redirect hides the FIFO contents in the same cycle it flushes them,
  // so decode never consumes a wrong-path instruction.
  assign inst_valid = (count_q != 2'd0) && !redirect;
  assign pop        = inst_valid && inst_ready;
  assign push       = (state_q == S_WAIT) && icache_valid && !redirect;
  assign new_entry  = '{pc: addr_q, inst: icache_data};

  // Write slot after the (optional) pop has shifted slot 1 into slot 0.
  assign wr_idx = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);

  // NOTE: every signal assigned in always_comb gets a default first so no
  // latch is inferred on paths that do not assign it.
  always_comb begin
    count_d = count_q;
    if (redirect) begin
      count_d = 2'd0;
    end else if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      latched_pc_q <= '0;
      req_q        <= 1'b0;
      count_q      <= 2'd0;
      // NOTE: the FIFO storage is reset as well because inst/inst_pc are
      // visible outputs that must read 0 out of reset; a pure data RAM with
      // a valid count would normally be left unreset.
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
    end else begin
      count_q <= count_d;

      // On pop-and-push with one entry, wr_idx is 0 and the later write of
      // new_entry overrides the shift into slot 0.
      if (pop) begin
        fifo_q[0] <= fifo_q[1];
      end
      if (push) begin
        fifo_q[wr_idx] <= new_entry;
      end

      unique case (state_q)
        S_IDLE: begin
          // icache_valid is ignored here: nothing is outstanding.
          if (redirect) begin
            state_q <= S_WAIT;
            addr_q  <= target_pc;
            req_q   <= 1'b1;
          end else if (count_q < 2'd2) begin
            state_q <= S_WAIT;
            addr_q  <= pc_q;
            req_q   <= 1'b1;
          end
        end

        S_WAIT: begin
          if (icache_valid) begin
            if (redirect) begin
              // Response belongs to the old path: drop it, request target.
              addr_q <= target_pc;
            end else if (count_d == 2'd2) begin
              // No room for another response: park the next address.
              state_q <= S_IDLE;
              pc_q    <= next_addr;
              req_q   <= 1'b0;
            end else begin
              addr_q <= next_addr;
            end
          end else if (redirect) begin
            // Request still in flight: keep it stable and drain its response.
            latched_pc_q <= target_pc;
            state_q      <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (icache_valid) begin
            state_q <= S_WAIT;
            addr_q  <= redirect ? target_pc : latched_pc_q;
          end else if (redirect) begin
            latched_pc_q <= target_pc;  // latest redirect wins
          end
        end

        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign icache_addr = addr_q;
  assign icache_req  = req_q;
  assign inst        = fifo_q[0].inst;
  assign inst_pc     = fifo_q[0].pc;

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage
//
// An icache model answers one cycle after a request with addr ^ A5A5_A5A5.
// Directed scenarios push the expected {pc, inst} stream into a queue; an
// independent monitor pops and compares on every accepted instruction.
// ----------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk          = 1'b0;
  logic        rst          = 1'b0;
  logic [31:0] icache_addr;
  logic        icache_req;
  logic [31:0] icache_data  = '0;
  logic        icache_valid = 1'b0;
  logic        redirect     = 1'b0;
  logic [31:0] redirect_pc  = '0;
  logic        inst_valid;
  logic        inst_ready   = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .icache_addr  (icache_addr),
    .icache_req   (icache_req),
    .icache_data  (icache_data),
    .icache_valid (icache_valid),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst         (inst),
    .inst_pc      (inst_pc)
  );

  always #5 clk = ~clk;

  // icache model: one valid pulse per request, one cycle after it is seen.
  always @(posedge clk) begin
    icache_valid <= icache_req && !icache_valid;
    icache_data  <= icache_addr ^ KEY;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every instruction that decode accepts at the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_inst: got pc %h expected none", inst_pc);
      end else begin
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e.pc);
        check("inst", inst, e.inst);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = pc ^ KEY;
    exp_q.push_back(e);
  endtask

  task automatic wait_empty(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Asserts rst mid-cycle, checks outputs immediately, then releases and
  // checks that the first request appears at the first edge after release.
  task automatic do_reset(input string name);
    redirect   = 1'b0;
    inst_ready = 1'b0;
    rst        = 1'b1;
    #1;
    check({name, "_rst_req"},        {31'b0, icache_req}, 32'd0);
    check({name, "_rst_addr"},       icache_addr,         RESET_PC);
    check({name, "_rst_inst_valid"}, {31'b0, inst_valid}, 32'd0);
    check({name, "_rst_inst"},       inst,                32'd0);
    check({name, "_rst_inst_pc"},    inst_pc,             32'd0);
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
    check({name, "_first_req"},  {31'b0, icache_req}, 32'd1);
    check({name, "_first_addr"}, icache_addr,         RESET_PC);
  endtask

  initial begin
    #2;

    // S1: streaming from reset with decode always ready.
    do_reset("s1");
    expect_pc(32'h0);
    expect_pc(32'h4);
    expect_pc(32'h8);
    expect_pc(32'hC);
    inst_ready = 1'b1;
    wait_empty("s1", 60);
    inst_ready = 1'b0;

    // S2: decode stalled -> FIFO fills with 0,4 and fetch stops.
    do_reset("s2");
    repeat (10) tick();
    check("s2_full_valid", {31'b0, inst_valid}, 32'd1);
    check("s2_full_pc",    inst_pc,             32'h0);
    check("s2_full_inst",  inst,                32'hA5A5_A5A5);
    check("s2_full_req",   {31'b0, icache_req}, 32'd0);
    expect_pc(32'h0);
    expect_pc(32'h4);
    expect_pc(32'h8);
    inst_ready = 1'b1;
    wait_empty("s2", 60);
    inst_ready = 1'b0;

    // S3: redirect in WAIT before the response -> DRAIN, stale data dropped.
    do_reset("s3");
    check("s3_no_valid_yet", {31'b0, icache_valid}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    check("s3_drain_req",  {31'b0, icache_req}, 32'd1);
    check("s3_drain_addr", icache_addr,         32'h0);
    tick();
    check("s3_new_addr", icache_addr,         32'h100);
    check("s3_new_req",  {31'b0, icache_req}, 32'd1);
    expect_pc(32'h100);
    expect_pc(32'h104);
    inst_ready = 1'b1;
    wait_empty("s3", 60);
    inst_ready = 1'b0;

    // S4: redirect coincident with icache_valid while FIFO holds one entry.
    do_reset("s4");
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (icache_valid && inst_valid) begin
          seen = 1'b1;
          break;
        end
        tick();
      end
      check("s4_setup_seen", {31'b0, seen}, 32'd1);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    check("s4_masked_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    redirect = 1'b0;
    check("s4_flushed", {31'b0, inst_valid}, 32'd0);
    check("s4_addr",    icache_addr,         32'h200);
    check("s4_req",     {31'b0, icache_req}, 32'd1);
    expect_pc(32'h200);
    expect_pc(32'h204);
    inst_ready = 1'b1;
    wait_empty("s4", 60);
    inst_ready = 1'b0;

    // S5: redirect near the top of the address space -> wrap to 0.
    do_reset("s5");
    expect_pc(32'hFFFF_FFF8);
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0000_0000);
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    wait_empty("s5", 80);
    inst_ready = 1'b0;

    // S6: reset pulse while WAIT with one buffered entry.
    do_reset("s6_pre");
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (inst_valid && icache_req && !icache_valid) begin
          seen = 1'b1;
          break;
        end
        tick();
      end
      check("s6_setup_seen", {31'b0, seen}, 32'd1);
      check("s6_setup_addr", icache_addr,   32'h4);
    end
    do_reset("s6");
    expect_pc(32'h0);
    expect_pc(32'h4);
    expect_pc(32'h8);
    inst_ready = 1'b1;
    wait_empty("s6", 60);
    inst_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
